block_unpack_buffer: RTL

- Streaming element realignment buffer: the consuming end of a packed element stream.
- Upstream writes groups of up to ELMS elements per cycle, packed from index 0. Downstream reads a window of the oldest elements and consumes a variable count per cycle.
- Internally it shifts consumed elements out toward index 0, the sequential counterpart of the combinational right block shift.
- Sits between fetch/pack stages and variable-width decode/issue stages.

---
 rtl/block_unpack_buffer.sv | 91 +++++++++
 1 files changed

// File: rtl/block_unpack_buffer.sv
// Element realignment buffer: upstream pushes packed groups, downstream reads the
// oldest ELMS elements and consumes a variable count per cycle; survivors shift to index 0.
module block_unpack_buffer #(
  parameter int ELMS = 8,
  parameter int DATA = 8,
  localparam int CNT = $clog2(ELMS + 1),
  localparam int DEPTH = 2 * ELMS,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELMS-1:0][DATA-1:0]  in_data,
  input  logic [CNT-1:0]             in_num,
  output logic [ELMS-1:0][DATA-1:0]  out_data,
  output logic [CNT-1:0]             out_avail,
  input  logic [CNT-1:0]             out_take,
  output logic [CW-1:0]              count
);

  localparam logic [CW-1:0]  ELMS_W = CW'(ELMS);
  localparam logic [CNT-1:0] ELMS_N = CNT'(ELMS);

  logic [DEPTH-1:0][DATA-1:0] mem;
  logic [DEPTH-1:0][DATA-1:0] mem_next;
  logic [DEPTH-1:0][DATA-1:0] shifted;
  logic [DEPTH-1:0][DATA-1:0] ins;
  logic [ELMS-1:0][DATA-1:0]  data_m;
  logic [CNT-1:0]             take_eff;
  logic [CNT-1:0]             num_eff;
  logic [CW-1:0]              base;
  logic [CW-1:0]              count_next;
  logic                       push;

  // Handshake: a group transfers on a cycle where in_valid & in_ready are both high.
  // in_ready depends on registered count only, so it never waits on out_take.
  assign in_ready  = (count <= ELMS_W);
  assign out_avail = (count > ELMS_W) ? ELMS_N : count[CNT-1:0];
  assign push      = in_valid & in_ready;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < ELMS; k++) begin
      out_data[k] = (CNT'(k) < out_avail) ? mem[k] : '0;
    end
  end

  always_comb begin
    take_eff = (out_take > out_avail) ? out_avail : out_take;
    num_eff  = (in_num > ELMS_N) ? ELMS_N : in_num;
    base     = count - CW'(take_eff);

    // Slots at or above count are always zero, so shifting and OR-ing in new data is safe.
    shifted = mem;
    for (int k = 0; k < ELMS; k++) begin
      if (CNT'(k) < take_eff) shifted = shifted >> DATA;
    end

    data_m = '0;
    for (int k = 0; k < ELMS; k++) begin
      data_m[k] = (CNT'(k) < num_eff) ? in_data[k] : '0;
    end

    ins = '0;
    ins[ELMS-1:0] = data_m;
    for (int k = 0; k < ELMS; k++) begin
      if (CW'(k) < base) ins = ins << DATA;
    end

    mem_next   = push ? (shifted | ins) : shifted;
    count_next = base + (push ? CW'(num_eff) : '0);

    if (flush) begin
      mem_next   = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mem   <= '0;
      count <= '0;
    end else begin
      mem   <= mem_next;
      count <= count_next;
    end
  end

endmodule
